// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: handshake bundle between N producers, the selector and one consumer.
// Producers and the consumer drive through the master modport; the selector uses slave.
interface mux_arb_n_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_chan;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_valid, sel, mode, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, sel, mode, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel, W-bit registered selector with valid/ready on every side.
// Channel choice is either the external sel (fixed mode) or a round-robin scan.
// Optional feature macro: MUX_RR_EN builds the round-robin path and its pointer;
// without it, mode is ignored and only fixed select exists.
module mux_arb_n #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = 2
) (
  input logic         clk,
  input logic         rst,
  mux_arb_n_if.slave  bus
);

  logic [SEL_W-1:0]  grantIdx_s;
  logic              grantValid_s;
  logic              fixedValid_s;
  logic              load_s;
  logic [WIDTH-1:0]  grantData_s;
  logic [NUM_IN-1:0] inReady_s;

  logic [WIDTH-1:0]  outData_r;
  logic [SEL_W-1:0]  outChan_r;
  logic              outValid_r;

  // Fixed candidate: a sel outside 0..NUM_IN-1 matches no channel, so no grant.
  always_comb begin
    fixedValid_s = 1'b0;
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (bus.sel == SEL_W'(i)) begin
        fixedValid_s = bus.in_valid[i];
      end else begin
        fixedValid_s = fixedValid_s;
      end
    end
  end

`ifdef MUX_RR_EN
  localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(NUM_IN - 1);
  localparam logic [NUM_IN-1:0] CH0_BIT = NUM_IN'(1'b1);

  logic [SEL_W-1:0] rrPtr_r;
  logic [SEL_W-1:0] rrIdx_s;
  logic             rrValid_s;
  int               scanIdx_s;

  // Round-robin candidate: first requesting channel at or above the pointer, wrapping.
  always_comb begin
    rrValid_s = 1'b0;
    rrIdx_s   = {SEL_W{1'b0}};
    scanIdx_s = 0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      scanIdx_s = (int'(rrPtr_r) + k) % int'(NUM_IN);
      if (!rrValid_s && (|(bus.in_valid & (CH0_BIT << scanIdx_s)))) begin
        rrValid_s = 1'b1;
        rrIdx_s   = SEL_W'(scanIdx_s);
      end else begin
        rrValid_s = rrValid_s;
      end
    end
  end

  // Pointer moves past the winner only when a round-robin word is actually taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr_r <= {SEL_W{1'b0}};
    end else if (load_s && bus.mode) begin
      rrPtr_r <= (grantIdx_s == LAST_CH) ? {SEL_W{1'b0}} : grantIdx_s + SEL_W'(1'b1);
    end else begin
      rrPtr_r <= rrPtr_r;
    end
  end

  // Grant source follows mode.
  always_comb begin
    grantValid_s = fixedValid_s;
    grantIdx_s   = bus.sel;
    if (bus.mode) begin
      grantValid_s = rrValid_s;
      grantIdx_s   = rrIdx_s;
    end else begin
      grantValid_s = fixedValid_s;
      grantIdx_s   = bus.sel;
    end
  end
`else
  logic unusedMode_s;
  assign unusedMode_s = bus.mode;

  // Only fixed select exists in this build; mode has no effect.
  always_comb begin
    grantValid_s = fixedValid_s;
    grantIdx_s   = bus.sel;
  end
`endif

  // Take a word when granted and the output slot is empty or draining this cycle.
  // Reset blocks acceptance so nothing is handshaken while the block is being cleared.
  always_comb begin
    load_s = grantValid_s & (~outValid_r | bus.out_ready) & ~rst;
  end

  // One-hot acceptance toward the granted producer, and its data word.
  always_comb begin
    inReady_s   = {NUM_IN{1'b0}};
    grantData_s = {WIDTH{1'b0}};
    for (int i = 0; i < int'(NUM_IN); i++) begin
      if (grantIdx_s == SEL_W'(i)) begin
        inReady_s[i] = load_s;
        grantData_s  = bus.in_data[i*WIDTH +: WIDTH];
      end else begin
        inReady_s[i] = 1'b0;
      end
    end
  end

  // Output slot: load replaces (even while draining), drain-only empties, stall holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      outData_r  <= {WIDTH{1'b0}};
      outChan_r  <= {SEL_W{1'b0}};
      outValid_r <= 1'b0;
    end else if (load_s) begin
      outData_r  <= grantData_s;
      outChan_r  <= grantIdx_s;
      outValid_r <= 1'b1;
    end else if (bus.out_ready) begin
      outData_r  <= outData_r;
      outChan_r  <= outChan_r;
      outValid_r <= 1'b0;
    end else begin
      outData_r  <= outData_r;
      outChan_r  <= outChan_r;
      outValid_r <= outValid_r;
    end
  end

  assign bus.in_ready  = inReady_s;
  assign bus.out_data  = outData_r;
  assign bus.out_chan  = outChan_r;
  assign bus.out_valid = outValid_r;

endmodule

// File: tb/tb_mux_arb_n.sv
// tb_mux_arb_n: directed and randomized checks of two mux_arb_n instances
// (16x4 and 8x3) against a transaction-level reference model.
module tb_mux_arb_n;

`ifdef MUX_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_arb_n_if #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) busA ();
  mux_arb_n_if #(.WIDTH(8),  .NUM_IN(3), .SEL_W(2)) busB ();

  mux_arb_n #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) dutA (.clk(clk), .rst(rst), .bus(busA));
  mux_arb_n #(.WIDTH(8),  .NUM_IN(3), .SEL_W(2)) dutB (.clk(clk), .rst(rst), .bus(busB));

  int chkCnt = 0;
  int errCnt = 0;

  // Reference model: contents of each output slot and each fairness pointer.
  int mValid[2];
  int mData[2];
  int mChan[2];
  int mPtr[2];
  int eLoad[2];
  int eGrant[2];

  task automatic checkVal(input string tag, input logic [31:0] got, input int exp);
    chkCnt++;
    if (got !== 32'(exp)) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Which channel wins under the stated arbitration rules (returns 1 if any).
  function automatic int findGrant(input int n, input int valid, input int sel,
                                   input bit mode, input int ptr, output int g);
    g = 0;
    if (RR_EN && mode) begin
      for (int k = 0; k < n; k++) begin
        if (((valid >> ((ptr + k) % n)) & 1) == 1) begin
          g = (ptr + k) % n;
          return 1;
        end
      end
      return 0;
    end
    if (sel < n && ((valid >> sel) & 1) == 1) begin
      g = sel;
      return 1;
    end
    return 0;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      mValid[i] = 0; mData[i] = 0; mChan[i] = 0; mPtr[i] = 0;
    end
  endtask

  task automatic checkCycle();
    int gv;
    gv = findGrant(4, int'(busA.in_valid), int'(busA.sel), busA.mode, mPtr[0], eGrant[0]);
    eLoad[0] = (gv == 1 && (mValid[0] == 0 || busA.out_ready) && !rst) ? 1 : 0;
    checkVal("A.inReady", 32'(busA.in_ready), (eLoad[0] == 1) ? (1 << eGrant[0]) : 0);
    checkVal("A.outValid", 32'(busA.out_valid), mValid[0]);
    checkVal("A.outData", 32'(busA.out_data), mData[0]);
    checkVal("A.outChan", 32'(busA.out_chan), mChan[0]);
    gv = findGrant(3, int'(busB.in_valid), int'(busB.sel), busB.mode, mPtr[1], eGrant[1]);
    eLoad[1] = (gv == 1 && (mValid[1] == 0 || busB.out_ready) && !rst) ? 1 : 0;
    checkVal("B.inReady", 32'(busB.in_ready), (eLoad[1] == 1) ? (1 << eGrant[1]) : 0);
    checkVal("B.outValid", 32'(busB.out_valid), mValid[1]);
    checkVal("B.outData", 32'(busB.out_data), mData[1]);
    checkVal("B.outChan", 32'(busB.out_chan), mChan[1]);
  endtask

  task automatic updateModel();
    if (rst) begin
      resetModel();
      return;
    end
    if (eLoad[0] == 1) begin
      mValid[0] = 1;
      mData[0]  = int'(busA.in_data[eGrant[0]*16 +: 16]);
      mChan[0]  = eGrant[0];
      if (RR_EN && busA.mode) mPtr[0] = (eGrant[0] + 1) % 4;
    end else if (busA.out_ready) begin
      mValid[0] = 0;
    end
    if (eLoad[1] == 1) begin
      mValid[1] = 1;
      mData[1]  = int'(busB.in_data[eGrant[1]*8 +: 8]);
      mChan[1]  = eGrant[1];
      if (RR_EN && busB.mode) mPtr[1] = (eGrant[1] + 1) % 3;
    end else if (busB.out_ready) begin
      mValid[1] = 0;
    end
  endtask

  // Inputs are set at the falling edge; check just after, advance model at the rising edge.
  task automatic cycle();
    #1;
    checkCycle();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    busA.in_data = 64'h0; busA.in_valid = 4'b1111; busA.sel = 2'd0; busA.mode = 1'b0; busA.out_ready = 1'b0;
    busB.in_data = 24'h0; busB.in_valid = 3'b000;  busB.sel = 2'd0; busB.mode = 1'b0; busB.out_ready = 1'b0;
    @(posedge clk);
    resetModel();
    @(negedge clk);

    // Reset with every channel requesting.
    cycle();
    checkVal("rstInReady", 32'(busA.in_ready), 0);
    checkVal("rstOutValid", 32'(busA.out_valid), 0);
    checkVal("rstOutData", 32'(busA.out_data), 0);
    checkVal("rstOutChan", 32'(busA.out_chan), 0);

    // Release: fixed sel=2 with ch2=BEEF; out-of-range sel on the 3-channel instance.
    rst = 1'b0;
    busA.sel = 2'd2; busA.in_data = 64'h1111_BEEF_3333_4444; busA.out_ready = 1'b1;
    busB.sel = 2'd3; busB.in_valid = 3'b111; busB.in_data = 24'hA1B2C3; busB.out_ready = 1'b1;
    #1;
    checkVal("relInReady", 32'(busA.in_ready), 4);
    cycle();
    checkVal("relData", 32'(busA.out_data), 16'hBEEF);
    checkVal("relChan", 32'(busA.out_chan), 2);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkVal("oorInReady", 32'(busB.in_ready), 0);
      checkVal("oorOutValid", 32'(busB.out_valid), 0);
    end

    // Empty the slot, then stall a fixed-select word on ch1.
    busA.in_valid = 4'b0000;
    cycle();
    busA.sel = 2'd1; busA.in_valid = 4'b0010; busA.in_data = 64'h0000_0000_0011_0000; busA.out_ready = 1'b0;
    cycle();
    busA.in_data = 64'h0000_0000_0022_0000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkVal("stallInReady", 32'(busA.in_ready), 0);
      checkVal("stallData", 32'(busA.out_data), 16'h0011);
    end
    busA.in_valid = 4'b0000; busA.out_ready = 1'b1;
    cycle();
    checkVal("drainValid", 32'(busA.out_valid), 0);

    // Back-to-back loads with a draining consumer: no bubble.
    busA.sel = 2'd0; busA.in_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      busA.in_data = {48'h0, 16'(16'h5A00 + i)};
      cycle();
      checkVal("b2bValid", 32'(busA.out_valid), 1);
      checkVal("b2bData", 32'(busA.out_data), 16'h5A00 + i);
    end

`ifdef MUX_RR_EN
    // Fairness from a fresh pointer: 0,1,2,3,0.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    busA.mode = 1'b1; busA.in_valid = 4'b1111; busA.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkVal("rrChan", 32'(busA.out_chan), i % 4);
    end
    cycle();
    checkVal("rrChanPtr2", 32'(busA.out_chan), 1);
    // Pointer is 2: only ch3 and ch1 request.
    busA.in_valid = 4'b1010;
    cycle();
    checkVal("rrSkip1", 32'(busA.out_chan), 3);
    cycle();
    checkVal("rrSkip2", 32'(busA.out_chan), 1);
    busA.in_valid = 4'b1111;
    cycle();
    checkVal("rrPtrEnd", 32'(busA.out_chan), 2);
`endif

    // Randomized traffic, including occasional resets and mode/sel changes.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      busA.in_data   = {$urandom, $urandom};
      busA.in_valid  = 4'($urandom);
      busA.sel       = 2'($urandom);
      busA.mode      = 1'($urandom);
      busA.out_ready = ($urandom_range(0, 9) < 7);
      busB.in_data   = 24'($urandom);
      busB.in_valid  = 3'($urandom);
      busB.sel       = 2'($urandom);
      busB.mode      = 1'($urandom);
      busB.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", chkCnt, errCnt);
    $finish;
  end

endmodule
